// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the mod_counter timer/event-count primitive.
package mod_counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Prescaler counter width; a single-cycle prescaler still keeps a 1-bit register.
  function automatic int calc_pw(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enabled-cycle divider: tick is high on the enabled cycle that completes a PRESCALE period.
module mod_counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int PW       = calc_pw(PRESCALE)
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;

  // With PRESCALE=1, LAST is 0 and count_q never leaves 0, so tick reduces to en.
  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulus counter with prescaler, load, clear, wrap/saturate,
// terminal-count pulse and sticky overflow.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam int PW = calc_pw(PRESCALE);
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

  if (MODULUS > (longint'(1) << WIDTH) || MODULUS < 2 || PRESCALE < 1) begin : g_bad_params
    $error("mod_counter: illegal MODULUS/PRESCALE for WIDTH");
  end

  logic [WIDTH-1:0] value_q, value_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic [WIDTH:0]   cur_ext, ld_ext, next_ext;

  mod_counter_prescaler #(
    .PRESCALE(PRESCALE),
    .PW      (PW)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .en     (en),
    .restart(clear | load),
    .tick   (tick)
  );

  assign cur_ext = {1'b0, value_q};
  assign ld_ext  = {1'b0, load_value};

  always_comb begin
    next_ext = cur_ext;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    if (clear) begin
      next_ext = '0;
      ovf_d    = 1'b0;
    end else if (load) begin
      next_ext = (ld_ext > MAXV) ? MAXV : ld_ext;
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (cur_ext == MAXV) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (sat_mode == MODE_WRAP) next_ext = '0;
        end else begin
          next_ext = cur_ext + (WIDTH+1)'(1);
        end
      end else begin
        // Bound in the down direction is zero; saturating holds it there.
        if (cur_ext == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (sat_mode == MODE_WRAP) next_ext = MAXV;
        end else begin
          next_ext = cur_ext - (WIDTH+1)'(1);
        end
      end
    end
    value_d = next_ext[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value = value_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign zero  = (value_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: directed scenarios plus a randomized run against an arithmetic model,
// on two instances (MODULUS=10 with PRESCALE=1 and PRESCALE=4) sharing the same inputs.
module tb_mod_counter;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, clear = 1'b0, load = 1'b0, up_dn = 1'b1, sat_mode = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic [7:0] v1, v4;
  logic       tc1, tc4, ovf1, ovf4, z1, z4;

  int n_checks = 0;
  int n_fail   = 0;

  mod_counter #(.WIDTH(8), .MODULUS(M), .PRESCALE(1)) dut1 (
    .clock(clk), .reset(reset), .en(en), .clear(clear), .load(load),
    .load_value(load_value), .up_dn(up_dn), .sat_mode(sat_mode),
    .value(v1), .tc(tc1), .ovf(ovf1), .zero(z1));

  mod_counter #(.WIDTH(8), .MODULUS(M), .PRESCALE(4)) dut4 (
    .clock(clk), .reset(reset), .en(en), .clear(clear), .load(load),
    .load_value(load_value), .up_dn(up_dn), .sat_mode(sat_mode),
    .value(v4), .tc(tc4), .ovf(ovf4), .zero(z4));

  always #5 clk = ~clk;

  // Reference model: value, enabled-cycle count within the current period, flags.
  typedef struct packed {
    logic [31:0] v;
    logic [31:0] p;
    logic        tc;
    logic        ovf;
  } st_t;

  st_t m0, m1;

  function automatic st_t nxt(input st_t s, input int ps);
    st_t n;
    int  v;
    n = s;
    n.tc = 1'b0;
    v = int'(s.v);
    if (clear) begin
      n.v = 0; n.p = 0; n.ovf = 1'b0;
    end else if (load) begin
      n.v = (int'(load_value) > M - 1) ? M - 1 : int'(load_value);
      n.p = 0;
    end else if (en) begin
      if (int'(s.p) + 1 < ps) begin
        n.p = s.p + 1;
      end else begin
        n.p = 0;
        if (up_dn) begin
          if (v == M - 1) begin n.tc = 1'b1; n.ovf = 1'b1; n.v = sat_mode ? v : 0; end
          else n.v = v + 1;
        end else begin
          if (v == 0) begin n.tc = 1'b1; n.ovf = 1'b1; n.v = sat_mode ? 0 : M - 1; end
          else n.v = v - 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= nxt(m0, 1);
      m1 <= nxt(m1, 4);
    end
  end

  task automatic test_reset();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    #14;  // t=16, after posedges at 5 and 15
    n_checks++;
    if (v1 !== 8'd2) begin n_fail++; $display("FAIL reset_precount value=%0d exp=2", v1); end
    #1 reset = 1'b1;  // t=17
    #1;
    n_checks++;
    if (v1 !== 8'd0 || tc1 !== 1'b0 || ovf1 !== 1'b0 || z1 !== 1'b1 || v4 !== 8'd0)
      begin n_fail++; $display("FAIL reset_async value=%0d tc=%b ovf=%b zero=%b v4=%0d exp=0/0/0/1/0", v1, tc1, ovf1, z1, v4); end
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_wrap_up();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      n_checks++;
      if (v1 !== 8'(i % M) || tc1 !== (i == 10) || ovf1 !== (i >= 10))
        begin n_fail++; $display("FAIL wrap_up step=%0d value=%0d tc=%b ovf=%b exp=%0d/%b/%b", i, v1, tc1, ovf1, i % M, i == 10, i >= 10); end
    end
    en = 1'b0;
  endtask

  task automatic test_sat_down();
    logic [7:0] ev [5] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic       ef [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; load = 1'b1; load_value = 8'd3; sat_mode = 1'b1; up_dn = 1'b0; en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (v1 !== 8'd3) begin n_fail++; $display("FAIL sat_load value=%0d exp=3", v1); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (v1 !== ev[i] || tc1 !== ef[i] || ovf1 !== ef[i])
        begin n_fail++; $display("FAIL sat_down step=%0d value=%0d tc=%b ovf=%b exp=%0d/%b/%b", i, v1, tc1, ovf1, ev[i], ef[i], ef[i]); end
    end
    en = 1'b0; sat_mode = 1'b0;
  endtask

  task automatic test_prescale();
    clear = 1'b1; en = 1'b1;
    @(negedge clk);
    clear = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (v4 !== 8'(k / 4) || tc4 !== 1'b0)
        begin n_fail++; $display("FAIL prescale cycle=%0d value=%0d tc=%b exp=%0d/0", k, v4, tc4, k / 4); end
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (v4 !== ((c == 6) ? 8'd3 : 8'd2))
        begin n_fail++; $display("FAIL prescale_stretch cycle=%0d value=%0d exp=%0d", c, v4, (c == 6) ? 3 : 2); end
      if (c == 4) begin
        n_checks++;
        if (v1 !== 8'd0) begin n_fail++; $display("FAIL en_freeze value=%0d exp=0", v1); end
      end
      if (c == 2) en = 1'b0;
      if (c == 4) en = 1'b1;
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    load = 1'b1; load_value = 8'd200;
    @(negedge clk);
    n_checks++;
    if (v1 !== 8'd9 || tc1 !== 1'b0) begin n_fail++; $display("FAIL load_clamp value=%0d tc=%b exp=9/0", v1, tc1); end
    load = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    @(negedge clk);
    n_checks++;
    if (v1 !== 8'd0 || tc1 !== 1'b1 || ovf1 !== 1'b1) begin n_fail++; $display("FAIL clamp_wrap value=%0d tc=%b ovf=%b exp=0/1/1", v1, tc1, ovf1); end
    en = 1'b0; load = 1'b1; load_value = 8'd10;
    @(negedge clk);
    n_checks++;
    if (v1 !== 8'd9 || ovf1 !== 1'b1 || tc1 !== 1'b0) begin n_fail++; $display("FAIL load_keeps_ovf value=%0d ovf=%b tc=%b exp=9/1/0", v1, ovf1, tc1); end
    clear = 1'b1; load_value = 8'd5;
    @(negedge clk);
    n_checks++;
    if (v1 !== 8'd0 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL clear_over_load value=%0d ovf=%b exp=0/0", v1, ovf1); end
    clear = 1'b0; load_value = 8'd4; en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (v1 !== 8'd4 || v4 !== 8'd4) begin n_fail++; $display("FAIL load_over_step value=%0d v4=%0d exp=4/4", v1, v4); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_dir_flip();
    load = 1'b1; load_value = 8'd9; up_dn = 1'b1; sat_mode = 1'b0;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (v1 !== 8'd8 || tc1 !== 1'b0 || z1 !== 1'b0) begin n_fail++; $display("FAIL dir_flip value=%0d tc=%b zero=%b exp=8/0/0", v1, tc1, z1); end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_checks++;
      if (v1 !== 8'(m0.v) || tc1 !== m0.tc || ovf1 !== m0.ovf || z1 !== (m0.v == 0))
        begin n_fail++; $display("FAIL rand_p1 cyc=%0d value=%0d tc=%b ovf=%b zero=%b exp=%0d/%b/%b/%b", i, v1, tc1, ovf1, z1, m0.v, m0.tc, m0.ovf, m0.v == 0); end
      n_checks++;
      if (v4 !== 8'(m1.v) || tc4 !== m1.tc || ovf4 !== m1.ovf || z4 !== (m1.v == 0))
        begin n_fail++; $display("FAIL rand_p4 cyc=%0d value=%0d tc=%b ovf=%b zero=%b exp=%0d/%b/%b/%b", i, v4, tc4, ovf4, z4, m1.v, m1.tc, m1.ovf, m1.v == 0); end
      reset      = ($urandom_range(63) == 0);
      en         = ($urandom_range(3) != 0);
      clear      = ($urandom_range(31) == 0);
      load       = ($urandom_range(15) == 0);
      load_value = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
      if ($urandom_range(7) == 0) up_dn = ~up_dn;
      if ($urandom_range(15) == 0) sat_mode = ~sat_mode;
    end
    reset = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_prescale();
    test_load_clamp();
    test_dir_flip();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
